threshold_sweep_source: RTL and testbench
=========================================

Name: threshold_sweep_source

Overview:
Sweep-stimulus writer that produces a signed 32-bit ramp and drives it into the negative-threshold comparator path over a valid/ready stream. Each beat carries the sample and the expected over-threshold flags, so the downstream checker can score comparator outputs beat by beat. It sits upstream of the sample FIFO in the threshold-check bench datapath and is the producer side of that stream.

Parameters:
START, -200, signed 32-bit first sample of the sweep
STOP, 0, signed 32-bit inclusive upper bound; no emitted sample exceeds it
STEP, 10, unsigned 31-bit increment per accepted beat; must be >= 1
THR_LO, -100, signed 32-bit low threshold used for the expected flag m_over_lo
THR_HI, -50, signed 32-bit high threshold used for the expected flag m_over_hi

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  pulse; begins a sweep when the block is idle
m_valid  output  1  beat valid
m_ready  input  1  downstream accepts the beat
m_data  output  32  signed sample
m_over_lo  output  1  expected result: m_data > THR_LO (signed)
m_over_hi  output  1  expected result: m_data > THR_HI (signed)
m_last  output  1  marks the final beat of the sweep
busy  output  1  high while in RUN
done  output  1  one-cycle pulse after the final beat is accepted
sample_count  output  16  beats accepted in the current or most recent sweep

Behaviour:
- Reset (rst_n=0 sampled at clk edge): state=IDLE. m_valid, m_last, busy and done are 0. m_data=0, m_over_lo=0, m_over_hi=0, sample_count=0. Reset mid-sweep aborts the sweep immediately, with no done pulse.
- Handshake: a beat transfers on a cycle with m_valid && m_ready. While m_valid=1 and m_ready=0, m_data, m_over_lo, m_over_hi and m_last hold stable. m_valid never drops without a transfer.
- FSM states are IDLE, RUN and DONE.
  - IDLE: if start=1, load cur=START, clear sample_count to 0, and go to RUN. m_valid rises in the next cycle, giving one cycle of latency from start to the first valid beat.
  - RUN: m_valid=1 and busy=1. m_data=cur. Flags use signed compares of cur against the thresholds.
  - RUN, last beat: m_last = (cur + STEP > STOP), evaluated in 33-bit signed arithmetic so it never wraps.
  - RUN, on transfer: sample_count increments and saturates at 16'hFFFF. If m_last=1, go to DONE; otherwise cur <= cur + STEP.
  - DONE: m_valid=0 and done=1 for exactly one cycle, then return to IDLE. sample_count holds until the next accepted start.
- start is ignored in RUN and DONE. A start in the DONE cycle is also ignored.
- If START > STOP, exactly one beat (START) is emitted, with m_last=1.
- m_over_lo and m_over_hi are registered or combinational from cur. Either way they are valid whenever m_valid=1. When idle they are 0.
- Flag semantics are strictly greater-than: equality gives 0.

Test Plan:
- Default params, start pulse, m_ready=1 -> 21 beats, m_data -200,-190,...,0. m_over_lo=0 for -200..-100 and 1 for -90..0. m_over_hi=1 for -40..0 only. m_last only on 0. done one cycle after the last beat. sample_count=21.
- Default params, m_ready pattern 1,0,0,1 repeating -> each beat is held stable across stall cycles. Same 21-value sequence, no duplicates or skips. sample_count=21.
- start re-pulsed at beat 5 and in the DONE cycle -> ignored. The sweep continues unchanged and no second sweep begins.
- rst_n=0 for 1 cycle after beat 7 -> next cycle: m_valid=0, sample_count=0, no done. A new start restarts at -200.
- START=2147483640, STOP=2147483647, STEP=5 -> beats 2147483640 and 2147483645 (m_last=1). No wrap to negative. sample_count=2.
- START=10, STOP=0 -> single beat 10 with m_last=1, m_over_lo=1, m_over_hi=1. done pulses. sample_count=1.

Source files
------------

// File: rtl/threshold_sweep_source.sv
// Ramp stimulus producer: emits START, START+STEP, ... up to STOP as a valid/ready stream,
// tagging each beat with the expected over-threshold flags for the downstream checker.
module threshold_sweep_source #(
   parameter logic signed [31:0] START  = -32'sd200,
   parameter logic signed [31:0] STOP   = 32'sd0,
   parameter logic        [30:0] STEP   = 31'd10,
   parameter logic signed [31:0] THR_LO = -32'sd100,
   parameter logic signed [31:0] THR_HI = -32'sd50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               m_valid,
   input  logic               m_ready,
   output logic signed [31:0] m_data,
   output logic               m_over_lo,
   output logic               m_over_hi,
   output logic               m_last,
   output logic               busy,
   output logic               done,
   output logic        [15:0] sample_count
);

   // Stream handshake: a beat moves on any cycle with m_valid && m_ready. While
   // m_valid is high and m_ready low, data, flags and m_last hold, and m_valid
   // stays asserted until the transfer happens.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic signed [31:0]  r_cur;
   logic        [15:0]  r_sample_count;

   logic signed [32:0]  w_next;
   logic                w_run;
   logic                w_last;

   // 33-bit sum so a sweep ending near the top of the signed range cannot wrap
   assign w_next = $signed({r_cur[31], r_cur}) + $signed({2'b00, STEP});
   assign w_run  = (r_state == S_RUN);
   assign w_last = w_run && (w_next > $signed({STOP[31], STOP}));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cur          <= '0;
         r_sample_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur          <= START;
                  r_sample_count <= '0;
                  r_state        <= S_RUN;
               end
            end
            S_RUN: begin
               if (m_ready) begin
                  if (r_sample_count != 16'hFFFF) begin
                     r_sample_count <= r_sample_count + 16'd1;
                  end
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_cur <= w_next[31:0];
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      m_valid      = w_run;
      busy         = w_run;
      done         = (r_state == S_DONE);
      m_data       = r_cur;
      m_last       = w_last;
      m_over_lo    = w_run && (r_cur > THR_LO);
      m_over_hi    = w_run && (r_cur > THR_HI);
      sample_count = r_sample_count;
   end

endmodule

// File: tb/tb_threshold_sweep_source.sv
// Bench for threshold_sweep_source: three instances cover the default sweep, a sweep at the
// top of the signed range, and a START > STOP single-beat sweep.
module tb_threshold_sweep_source;

   logic               clk;
   logic               rst_n;
   logic               start_v   [3];
   logic               ready_v   [3];
   logic               valid     [3];
   logic signed [31:0] data      [3];
   logic               lo        [3];
   logic               hi        [3];
   logic               last      [3];
   logic               busy      [3];
   logic               done      [3];
   logic        [15:0] sc        [3];

   // beat packing: {last, over_hi, over_lo, data}
   logic [34:0] exp_q[$];
   logic [34:0] obs_q[$];

   int n_checks;
   int n_fail;

   int hold_err;
   int busy_err;
   int done_cnt;
   int done_gap;
   int extra_valid;
   bit lat_ok;
   bit timeout;

   threshold_sweep_source u_def (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .m_valid(valid[0]), .m_ready(ready_v[0]), .m_data(data[0]),
      .m_over_lo(lo[0]), .m_over_hi(hi[0]), .m_last(last[0]),
      .busy(busy[0]), .done(done[0]), .sample_count(sc[0])
   );

   threshold_sweep_source #(
      .START(32'sd2147483640), .STOP(32'sd2147483647), .STEP(31'd5)
   ) u_top (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .m_valid(valid[1]), .m_ready(ready_v[1]), .m_data(data[1]),
      .m_over_lo(lo[1]), .m_over_hi(hi[1]), .m_last(last[1]),
      .busy(busy[1]), .done(done[1]), .sample_count(sc[1])
   );

   threshold_sweep_source #(
      .START(32'sd10), .STOP(32'sd0)
   ) u_rev (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .m_valid(valid[2]), .m_ready(ready_v[2]), .m_data(data[2]),
      .m_over_lo(lo[2]), .m_over_hi(hi[2]), .m_last(last[2]),
      .busy(busy[2]), .done(done[2]), .sample_count(sc[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ramp with thresholds -100 / -50, evaluated in 64-bit arithmetic
   function automatic void gen(input longint st, input longint sp, input longint stp);
      longint cur;
      logic   l;
      logic   h;
      logic   o;
      cur = st;
      for (int k = 0; k < 1000; k++) begin
         l = (cur + stp > sp);
         o = (cur > -100);
         h = (cur > -50);
         exp_q.push_back({l, h, o, cur[31:0]});
         if (l) break;
         cur = cur + stp;
      end
   endfunction

   // Runs one sweep on instance idx and records what the DUT produced.
   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
   task automatic collect(input int idx, input int mode, input bit repulse);
      int          cyc;
      int          beats;
      int          last_xfer;
      int          after;
      bit          prev_stall;
      bit          seen_done;
      logic        rdy;
      logic [34:0] cur_beat;
      logic [34:0] prev_beat;
      obs_q.delete();
      hold_err = 0; busy_err = 0; done_cnt = 0; done_gap = -1;
      extra_valid = 0; timeout = 0;
      cyc = 0; beats = 0; last_xfer = -1; after = 0;
      prev_stall = 0; seen_done = 0; prev_beat = '0;
      @(negedge clk);
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
      lat_ok = valid[idx];
      forever begin
         start_v[idx] = 1'b0;
         cur_beat = {last[idx], hi[idx], lo[idx], data[idx]};
         if (valid[idx] && prev_stall && cur_beat !== prev_beat) hold_err++;
         if (prev_stall && !valid[idx]) hold_err++;
         if (busy[idx] !== valid[idx]) busy_err++;
         rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         ready_v[idx] = rdy;
         if (done[idx]) begin
            done_cnt++;
            if (done_gap < 0) done_gap = cyc - last_xfer;
            seen_done = 1;
            if (repulse) start_v[idx] = 1'b1;
         end else if (seen_done) begin
            after++;
            if (valid[idx]) extra_valid++;
         end
         if (valid[idx] && rdy) begin
            obs_q.push_back(cur_beat);
            beats++;
            last_xfer = cyc;
            if (repulse && beats == 5) start_v[idx] = 1'b1;
         end
         prev_stall = valid[idx] && !rdy;
         prev_beat  = cur_beat;
         if (after >= 6) break;
         if (cyc > 2000) begin
            timeout = 1;
            break;
         end
         cyc++;
         @(negedge clk);
      end
      ready_v[idx] = 1'b0;
      start_v[idx] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         ready_v[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({valid[i], last[i], busy[i], done[i], lo[i], hi[i]} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d]: got v/l/b/d/lo/hi=%b%b%b%b%b%b expected 000000",
                     i, valid[i], last[i], busy[i], done[i], lo[i], hi[i]);
         end
         n_checks++;
         if (data[i] !== 32'sd0 || sc[i] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data[%0d]: got data=%0d count=%0d expected 0 and 0", i, data[i], sc[i]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_rate;
      logic [34:0] o;
      logic [34:0] e;
      gen(-200, 0, 10);
      collect(0, 0, 0);
      n_checks++;
      if (timeout) begin n_fail++; $display("FAIL full_rate_timeout: sweep did not finish, required done within budget"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL full_rate_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL full_rate_beat: got data=%0d l/h/lo=%b%b%b expected data=%0d l/h/lo=%b%b%b",
                     $signed(o[31:0]), o[34], o[33], o[32], $signed(e[31:0]), e[34], e[33], e[32]);
         end
      end
      exp_q.delete();
      n_checks++;
      if (!lat_ok) begin n_fail++; $display("FAIL full_rate_latency: got valid=0 expected valid=1 one cycle after start"); end
      n_checks++;
      if (done_cnt != 1 || done_gap != 1) begin
         n_fail++; $display("FAIL full_rate_done: got pulses=%0d gap=%0d expected 1 and 1", done_cnt, done_gap);
      end
      n_checks++;
      if (busy_err != 0) begin n_fail++; $display("FAIL full_rate_busy: got %0d busy/valid mismatches expected 0", busy_err); end
      n_checks++;
      if (sc[0] !== 16'd21) begin n_fail++; $display("FAIL full_rate_sample_count: got %0d expected 21", sc[0]); end
   endtask

   task automatic test_stall;
      logic [34:0] o;
      logic [34:0] e;
      gen(-200, 0, 10);
      collect(0, 1, 0);
      n_checks++;
      if (timeout) begin n_fail++; $display("FAIL stall_timeout: sweep did not finish, required done within budget"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall_beat: got data=%0d l/h/lo=%b%b%b expected data=%0d l/h/lo=%b%b%b",
                     $signed(o[31:0]), o[34], o[33], o[32], $signed(e[31:0]), e[34], e[33], e[32]);
         end
      end
      exp_q.delete();
      n_checks++;
      if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", hold_err); end
      n_checks++;
      if (done_cnt != 1 || done_gap != 1) begin
         n_fail++; $display("FAIL stall_done: got pulses=%0d gap=%0d expected 1 and 1", done_cnt, done_gap);
      end
      n_checks++;
      if (sc[0] !== 16'd21) begin n_fail++; $display("FAIL stall_sample_count: got %0d expected 21", sc[0]); end
   endtask

   task automatic test_repulse;
      logic [34:0] o;
      logic [34:0] e;
      gen(-200, 0, 10);
      collect(0, 0, 1);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL repulse_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL repulse_beat: got data=%0d expected data=%0d", $signed(o[31:0]), $signed(e[31:0]));
         end
      end
      exp_q.delete();
      n_checks++;
      if (extra_valid != 0 || done_cnt != 1) begin
         n_fail++; $display("FAIL repulse_second_sweep: got extra_valid=%0d pulses=%0d expected 0 and 1", extra_valid, done_cnt);
      end
      n_checks++;
      if (sc[0] !== 16'd21) begin n_fail++; $display("FAIL repulse_sample_count: got %0d expected 21", sc[0]); end
   endtask

   task automatic test_reset_abort;
      int          beats;
      int          cyc;
      int          stray;
      logic [34:0] o;
      @(negedge clk);
      start_v[0] = 1'b1;
      ready_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      beats = 0; cyc = 0;
      while (beats < 7 && cyc < 100) begin
         if (valid[0]) beats++;
         cyc++;
         @(negedge clk);
      end
      n_checks++;
      if (beats != 7) begin n_fail++; $display("FAIL abort_reach: got %0d beats expected 7", beats); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ready_v[0] = 1'b0;
      n_checks++;
      if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
         n_fail++; $display("FAIL abort_ctrl: got valid=%b busy=%b done=%b expected 000", valid[0], busy[0], done[0]);
      end
      n_checks++;
      if (sc[0] !== 16'd0) begin n_fail++; $display("FAIL abort_sample_count: got %0d expected 0", sc[0]); end
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (done[0] || valid[0]) stray++;
      end
      n_checks++;
      if (stray != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", stray); end
      gen(-200, 0, 10);
      collect(0, 0, 0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL abort_restart_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      if (obs_q.size() > 0) begin
         o = obs_q[0];
         n_checks++;
         if ($signed(o[31:0]) !== -32'sd200) begin
            n_fail++; $display("FAIL abort_restart_first: got %0d expected -200", $signed(o[31:0]));
         end
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         n_checks++;
         if (obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL abort_restart_beat: got data=%0d expected data=%0d",
                     $signed(obs_q[0][31:0]), $signed(exp_q[0][31:0]));
         end
         void'(obs_q.pop_front());
         void'(exp_q.pop_front());
      end
      exp_q.delete();
      n_checks++;
      if (sc[0] !== 16'd21) begin n_fail++; $display("FAIL abort_restart_sample_count: got %0d expected 21", sc[0]); end
   endtask

   task automatic test_top_of_range;
      logic [34:0] o;
      logic [34:0] e;
      gen(64'sd2147483640, 64'sd2147483647, 5);
      collect(1, 1, 0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL top_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL top_beat: got data=%0d l/h/lo=%b%b%b expected data=%0d l/h/lo=%b%b%b",
                     $signed(o[31:0]), o[34], o[33], o[32], $signed(e[31:0]), e[34], e[33], e[32]);
         end
      end
      exp_q.delete();
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL top_done: got %0d pulses expected 1", done_cnt); end
      n_checks++;
      if (sc[1] !== 16'd2) begin n_fail++; $display("FAIL top_sample_count: got %0d expected 2", sc[1]); end
   endtask

   task automatic test_start_above_stop;
      logic [34:0] o;
      logic [34:0] e;
      gen(10, 0, 10);
      collect(2, 0, 0);
      n_checks++;
      if (obs_q.size() != 1) begin n_fail++; $display("FAIL rev_count: got %0d beats expected 1", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rev_beat: got data=%0d l/h/lo=%b%b%b expected data=%0d l/h/lo=%b%b%b",
                     $signed(o[31:0]), o[34], o[33], o[32], $signed(e[31:0]), e[34], e[33], e[32]);
         end
      end
      exp_q.delete();
      n_checks++;
      if (done_cnt != 1 || done_gap != 1) begin
         n_fail++; $display("FAIL rev_done: got pulses=%0d gap=%0d expected 1 and 1", done_cnt, done_gap);
      end
      n_checks++;
      if (sc[2] !== 16'd1) begin n_fail++; $display("FAIL rev_sample_count: got %0d expected 1", sc[2]); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_full_rate();
      test_stall();
      test_repulse();
      test_reset_abort();
      test_top_of_range();
      test_start_above_stop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
